// File: rtl/bist_netlist_wrapper.sv
// Self-test wrapper for a combinational netlist: an LFSR drives its inputs and
// a MISR compacts its outputs into a signature checked against a golden value.
module bist_netlist_wrapper #(
  parameter int              IN_W     = 10,
  parameter int              OUT_W    = 4,
  parameter int              SIG_W    = 16,
  parameter int              N_PAT    = 256,
  parameter logic [IN_W-1:0] IN_TAPS  = 10'h240,
  parameter logic [SIG_W-1:0] SIG_TAPS = 16'hB400,
  parameter logic [IN_W-1:0] SEED     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  pat,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [SIG_W-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             pass
);

  localparam int CNT_W = $clog2(N_PAT) + 1;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [IN_W-1:0]  SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [IN_W-1:0]  pat_step;
  logic [SIG_W-1:0] sig_step;

  always_comb begin
    pat_step = {pat[IN_W-2:0], ^(pat & IN_TAPS)};
    sig_step = {signature[SIG_W-2:0], 1'b0}
             ^ (signature[SIG_W-1] ? SIG_TAPS : '0)
             ^ SIG_W'(dut_out);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pat       <= SEED_EFF;
      signature <= '0;
      count     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            pat       <= SEED_EFF;
            signature <= '0;
            count     <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            signature <= sig_step;
            count     <= count + 1'b1;
            // The last vector stays on pat so it remains observable in DONE.
            if (count == LAST_CNT) state <= S_DONE;
            else                   pat   <= pat_step;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign pass = done && (signature == golden);

endmodule

// File: tb/tb_bist_netlist_wrapper.sv
// Directed bench for bist_netlist_wrapper: three instances (N_PAT 256, 4, 1023)
// checked against hand-computed values and a small LFSR/MISR reference model.
module tb_bist_netlist_wrapper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: N_PAT=256
  logic        start_a = 1'b0;
  logic [3:0]  out_a   = 4'h0;
  logic [15:0] gold_a  = 16'h0;
  logic [9:0]  pat_a;
  logic [15:0] sig_a;
  logic        busy_a, done_a, pass_a;

  // Instance B: N_PAT=4
  logic        start_b = 1'b0;
  logic [3:0]  out_b   = 4'h1;
  logic [15:0] gold_b  = 16'h000F;
  logic [9:0]  pat_b;
  logic [15:0] sig_b;
  logic        busy_b, done_b, pass_b;

  // Instance C: N_PAT=1023, outputs driven by a small combinational netlist
  logic        start_c = 1'b0;
  logic [3:0]  out_c;
  logic [15:0] gold_c  = 16'h0;
  logic [9:0]  pat_c;
  logic [15:0] sig_c;
  logic        busy_c, done_c, pass_c;

  function automatic logic [9:0] lfsr_step(input logic [9:0] p);
    return {p[8:0], p[9] ^ p[6]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'hB400 : 16'h0000) ^ {12'h000, d};
  endfunction

  function automatic logic [3:0] netlist(input logic [9:0] p);
    return p[3:0] ^ {p[9:7], p[5]};
  endfunction

  assign out_c = netlist(pat_c);

  bist_netlist_wrapper #(.N_PAT(256)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .pat(pat_a),
    .dut_out(out_a), .golden(gold_a), .busy(busy_a), .done(done_a),
    .signature(sig_a), .pass(pass_a)
  );

  bist_netlist_wrapper #(.N_PAT(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .pat(pat_b),
    .dut_out(out_b), .golden(gold_b), .busy(busy_b), .done(done_b),
    .signature(sig_b), .pass(pass_b)
  );

  bist_netlist_wrapper #(.N_PAT(1023)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort), .pat(pat_c),
    .dut_out(out_c), .golden(gold_c), .busy(busy_c), .done(done_c),
    .signature(sig_c), .pass(pass_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [9:0]  lfsr_exp [8] = '{10'h001, 10'h002, 10'h004, 10'h008,
                                10'h010, 10'h020, 10'h040, 10'h081};
  logic [15:0] sig4_exp [4] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};

  initial begin
    int          n;
    int          zero_hits;
    int          repeats;
    bit          seen [1024];
    logic [9:0]  mp;
    logic [15:0] ms;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rst_pat", pat_a, 10'h001);
    check("rst_sig", sig_a, 16'h0000);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_pass", pass_a, 1'b0);

    // A: dut_out=0, 256 patterns, golden 0
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    n = 0;
    while (busy_a && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("a_busy_cycles", n, 256);
    check("a_done", done_a, 1'b1);
    check("a_sig", sig_a, 16'h0000);
    check("a_pass", pass_a, 1'b1);

    // A: LFSR sequence from seed 1, then reset mid-run
    out_a   = 4'h1;
    start_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) start_a = 1'b0;
      check($sformatf("lfsr_%0d", i), pat_a, lfsr_exp[i]);
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("midrst_pat", pat_a, 10'h001);
    check("midrst_sig", sig_a, 16'h0000);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_done", done_a, 1'b0);
    check("midrst_pass", pass_a, 1'b0);

    // A: abort on the third RUN cycle
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    @(negedge clk);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_busy", busy_a, 1'b0);
    check("abort_done", done_a, 1'b0);
    check("abort_sig", sig_a, 16'h0003);
    check("abort_pat", pat_a, 10'h004);

    // A: start and abort together in IDLE starts a run
    start_a = 1'b1;
    abort   = 1'b1;
    @(negedge clk) begin start_a = 1'b0; abort = 1'b0; end
    check("sa_idle_busy", busy_a, 1'b1);
    check("sa_idle_sig", sig_a, 16'h0000);
    check("sa_idle_pat", pat_a, 10'h001);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("sa_abort_busy", busy_a, 1'b0);

    // B: N_PAT=4, dut_out=1
    start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    check("b_busy0", busy_b, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b_sig_%0d", i), sig_b, sig4_exp[i]);
      check($sformatf("b_done_%0d", i), done_b, (i == 3) ? 1'b1 : 1'b0);
    end
    check("b_pass", pass_b, 1'b1);
    gold_b = 16'h000E;
    #1 check("b_pass_wrong_golden", pass_b, 1'b0);
    gold_b = 16'h000F;
    abort  = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    check("b_done_hold", done_b, 1'b1);
    check("b_sig_hold", sig_b, 16'h000F);
    check("b_pat_hold", pat_b, 10'h008);

    // B: start in DONE reloads; start held into RUN is ignored
    start_b = 1'b1;
    @(negedge clk);
    check("b2_busy", busy_b, 1'b1);
    check("b2_sig_clr", sig_b, 16'h0000);
    check("b2_pat_seed", pat_b, 10'h001);
    @(negedge clk);
    @(negedge clk) start_b = 1'b0;
    @(negedge clk);
    check("b2_busy_late", busy_b, 1'b1);
    @(negedge clk);
    check("b2_done", done_b, 1'b1);
    check("b2_sig", sig_b, 16'h000F);
    check("b2_pass", pass_b, 1'b1);

    // C: full-period LFSR run through a real netlist function
    mp = 10'h001;
    ms = 16'h0000;
    for (int i = 0; i < 1023; i++) begin
      ms = misr_step(ms, netlist(mp));
      if (i != 1022) mp = lfsr_step(mp);
    end
    gold_c    = ms;
    zero_hits = 0;
    repeats   = 0;
    start_c   = 1'b1;
    @(negedge clk) start_c = 1'b0;
    n = 0;
    while (busy_c && n < 1100) begin
      if (pat_c == 10'h000) zero_hits++;
      if (seen[pat_c]) repeats++;
      seen[pat_c] = 1'b1;
      n++;
      @(negedge clk);
    end
    check("c_busy_cycles", n, 1023);
    check("c_zero_hits", zero_hits, 0);
    check("c_repeats", repeats, 0);
    check("c_last_pat", pat_c, mp);
    check("c_wraps_to_seed", lfsr_step(pat_c), 10'h001);
    check("c_sig", sig_c, ms);
    check("c_pass", pass_c, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
